// File: rtl/pipelined_cla_addsub.sv
// -----------------------------------------------------------------------------
// pipelined_cla_addsub
//   Pipelined carry-lookahead adder/subtractor with signed-saturating modes and
//   Z/N/V/C flags. The operands are split into SLICE-bit lookahead slices. Each
//   slice is resolved in its own pipeline stage, and the carry is registered
//   between stages. The last stage resolves saturation and the flags and
//   registers them together with the sum. A global advance signal gives full
//   throughput and backpressure.
//
// Parameters
//   WIDTH        operand/result width, a positive multiple of SLICE
//   SLICE        bits per lookahead slice (one pipeline stage per slice)
//
// Ports
//   i_clk        clock, all state updates on the rising edge
//   i_rst_n      synchronous active-low reset
//   i_in_valid   operand beat present
//   o_in_ready   beat can be accepted this cycle (= advance)
//   i_a, i_b     operands
//   i_cin        carry-in, used only by ADD
//   i_op         00 ADD, 01 SUB, 10 SATADD, 11 SATSUB
//   o_out_valid  result beat present
//   i_out_ready  consumer accepts result
//   o_sum        final (possibly saturated) result
//   o_cout       raw carry out of the MSB
//   o_ovfl       signed overflow of the raw result
//   o_zero       o_sum == 0
//   o_neg        o_sum[WIDTH-1]
// -----------------------------------------------------------------------------
module pipelined_cla_addsub #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  input  logic [1:0]       i_op,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_ovfl,
  output logic             o_zero,
  output logic             o_neg
);

  localparam int L  = WIDTH / SLICE;
  // Number of intermediate stage registers; the last stage is the output register.
  localparam int NR = (L > 1) ? L - 1 : 1;

  // One lookahead slice: returns {carry_out, sum}.
  function automatic logic [SLICE:0] cla_slice(input logic [SLICE-1:0] x,
                                               input logic [SLICE-1:0] y,
                                               input logic             c0);
    logic [SLICE-1:0] g;
    logic [SLICE-1:0] p;
    logic [SLICE:0]   c;
    g    = x & y;
    p    = x ^ y;
    c[0] = c0;
    for (int i = 0; i < SLICE; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    return {c[SLICE], p ^ c[SLICE-1:0]};
  endfunction

  logic w_adv;

  // Inputs seen by stage k: from the ports for k = 0, else from stage k-1.
  logic             w_v_in   [L];
  logic [WIDTH-1:0] w_a_in   [L];
  logic [WIDTH-1:0] w_b_in   [L];
  logic [WIDTH-1:0] w_s_in   [L];
  logic             w_c_in   [L];
  logic             w_sat_in [L];
  logic [SLICE:0]   w_res    [L];
  logic [WIDTH-1:0] w_s_out  [L];

  // Intermediate stage registers.
  logic             r_v   [NR];
  logic [WIDTH-1:0] r_a   [NR];
  logic [WIDTH-1:0] r_b   [NR];
  logic [WIDTH-1:0] r_s   [NR];
  logic             r_c   [NR];
  logic             r_sat [NR];

  // Output stage registers.
  logic             r_out_valid;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovfl;
  logic             r_zero;
  logic             r_neg;

  assign w_adv      = !r_out_valid || i_out_ready;
  assign o_in_ready = w_adv;

  for (genvar gi = 0; gi < L; gi++) begin : g_stage
    if (gi == 0) begin : g_first
      assign w_v_in[gi]   = i_in_valid;
      assign w_a_in[gi]   = i_a;
      // Subtraction is a + ~b + 1. SATADD forces carry-in to 0.
      assign w_b_in[gi]   = i_op[0] ? ~i_b : i_b;
      assign w_c_in[gi]   = i_op[0] | (~i_op[1] & i_cin);
      assign w_s_in[gi]   = '0;
      // Only the saturate bit of op is needed past this point.
      assign w_sat_in[gi] = i_op[1];
    end else begin : g_next
      assign w_v_in[gi]   = r_v[gi-1];
      assign w_a_in[gi]   = r_a[gi-1];
      assign w_b_in[gi]   = r_b[gi-1];
      assign w_c_in[gi]   = r_c[gi-1];
      assign w_s_in[gi]   = r_s[gi-1];
      assign w_sat_in[gi] = r_sat[gi-1];
    end

    assign w_res[gi]   = cla_slice(SLICE'(w_a_in[gi] >> (gi * SLICE)),
                                   SLICE'(w_b_in[gi] >> (gi * SLICE)),
                                   w_c_in[gi]);
    // Upper bits of the partial sum are still zero, so OR-in the new slice.
    assign w_s_out[gi] = w_s_in[gi] | (WIDTH'(w_res[gi][SLICE-1:0]) << (gi * SLICE));
  end

  // Final-stage resolution of overflow, saturation and flags.
  logic [WIDTH-1:0] w_raw;
  logic [WIDTH-1:0] w_sat_val;
  logic [WIDTH-1:0] w_final;
  logic             w_a_msb;
  logic             w_b_msb;
  logic             w_ovfl;

  assign w_raw     = w_s_out[L-1];
  assign w_a_msb   = w_a_in[L-1][WIDTH-1];
  assign w_b_msb   = w_b_in[L-1][WIDTH-1];
  assign w_ovfl    = (w_a_msb == w_b_msb) && (w_raw[WIDTH-1] != w_a_msb);
  // On overflow the true result lies beyond the sign of a.
  assign w_sat_val = w_a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  assign w_final   = (w_sat_in[L-1] && w_ovfl) ? w_sat_val : w_raw;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int k = 0; k < NR; k++) begin
        r_v[k]   <= 1'b0;
        r_a[k]   <= '0;
        r_b[k]   <= '0;
        r_s[k]   <= '0;
        r_c[k]   <= 1'b0;
        r_sat[k] <= 1'b0;
      end
      r_out_valid <= 1'b0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_ovfl      <= 1'b0;
      r_zero      <= 1'b0;
      r_neg       <= 1'b0;
    end else if (w_adv) begin
      for (int k = 0; k < L - 1; k++) begin
        r_v[k]   <= w_v_in[k];
        r_a[k]   <= w_a_in[k];
        r_b[k]   <= w_b_in[k];
        r_s[k]   <= w_s_out[k];
        r_c[k]   <= w_res[k][SLICE];
        r_sat[k] <= w_sat_in[k];
      end
      r_out_valid <= w_v_in[L-1];
      r_sum       <= w_final;
      r_cout      <= w_res[L-1][SLICE];
      r_ovfl      <= w_ovfl;
      r_zero      <= (w_final == '0);
      r_neg       <= w_final[WIDTH-1];
    end
  end

  assign o_out_valid = r_out_valid;
  assign o_sum       = r_sum;
  assign o_cout      = r_cout;
  assign o_ovfl      = r_ovfl;
  assign o_zero      = r_zero;
  assign o_neg       = r_neg;

endmodule
